if_stage: RTL and testbench

- Instruction-fetch stage for the 16-bit WISC core. It sits between a variable-latency instruction memory and decode.
- Owns the PC register and issues requests on a req/rdy memory handshake. It holds one fetched instruction in an output buffer until decode accepts it.
- Handles branch redirects, including discarding a fetch already in flight. It stops fetching after a HLT instruction.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 112 +++++++++++
 tb/tb_if_stage.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction memory request/response bundle.
// The fetch stage is the master, the memory the slave.
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage for the 16-bit WISC core.
// Owns the PC, one-entry output buffer, redirect drain and halt.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] hold_addr;
  logic        pend;
  logic        req;
  logic        consume;
  logic        rdy;

  assign rdy     = imem.imem_rdy;
  assign consume = instr_valid & ~stall;

  // Request while a fetch is outstanding, while draining, or when the
  // buffer will be free; an outstanding fetch keeps its original address.
  always_comb begin
    req = 1'b0;
    if (pend || state == DRAIN) begin
      req = 1'b1;
    end else if (state == RUN && !redirect) begin
      req = !instr_valid || !stall;
    end
    imem.imem_req  = req;
    imem.imem_addr = pend ? hold_addr : pc;
  end

  // PC, pending flag, output buffer and RUN/DRAIN/HALT sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      hold_addr   <= RESET_PC;
      pend        <= 1'b0;
      instr_out   <= 16'h0000;
      pc_out      <= 16'h0000;
      pc_plus     <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (!pend) begin
        hold_addr <= pc;
      end
      if (rdy) begin
        pend <= 1'b0;
      end else if (req) begin
        pend <= 1'b1;
      end
      if (redirect) begin
        pc          <= redirect_pc;
        instr_valid <= 1'b0;
        halted      <= 1'b0;
        state       <= (pend && !rdy) ? DRAIN : RUN;
      end else begin
        unique case (state)
          RUN: begin
            if (rdy) begin
              instr_out   <= imem.imem_data;
              pc_out      <= pc;
              pc_plus     <= pc + PC_INC;
              instr_valid <= 1'b1;
              pc          <= pc + PC_INC;
              if (imem.imem_data[15:12] == HLT_OP) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end else if (consume) begin
              instr_valid <= 1'b0;
            end
          end
          DRAIN: begin
            if (rdy) begin
              state <= RUN;
            end
          end
          HALT: begin
            if (consume) begin
              instr_valid <= 1'b0;
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, latency,
// stall, redirect/drain, halt, wrap and reset.
module tb_if_stage;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus;
  logic        instr_valid;
  logic        halted;
  int          checks;
  int          errors;

  if_stage_if bus ();

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus     (pc_plus),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    bus.imem_rdy = 1'b0;
    bus.imem_data = 16'h0000;
    checks = 0;
    errors = 0;
    cyc();
    cyc();
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_pc_plus", pc_plus, 16'h0000);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);

    // zero-wait fetch stream
    rst = 1'b0;
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h1234;
    #1;
    chk1("t1_req0", bus.imem_req, 1'b1);
    chk("t1_addr0", bus.imem_addr, 16'h0000);
    cyc();
    chk("t1_instr0", instr_out, 16'h1234);
    chk("t1_pc_out0", pc_out, 16'h0000);
    chk("t1_pc_plus0", pc_plus, 16'h0002);
    chk1("t1_valid0", instr_valid, 1'b1);
    bus.imem_data = 16'h5678;
    #1;
    chk1("t1_req1", bus.imem_req, 1'b1);
    chk("t1_addr1", bus.imem_addr, 16'h0002);
    cyc();
    chk("t1_instr1", instr_out, 16'h5678);
    chk("t1_pc_out1", pc_out, 16'h0002);
    chk("t1_pc_plus1", pc_plus, 16'h0004);
    bus.imem_data = 16'h9ABC;
    #1;
    chk("t1_addr2", bus.imem_addr, 16'h0004);
    cyc();
    chk("t1_pc_out2", pc_out, 16'h0004);

    // 3-cycle latency with stall after first capture
    bus.imem_rdy = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h1111;
    #1;
    chk("t2_addr0", bus.imem_addr, 16'h0000);
    cyc();
    bus.imem_rdy = 1'b0;
    stall = 1'b1;
    repeat (5) begin
      #1;
      chk1("t2_stall_req", bus.imem_req, 1'b0);
      chk("t2_stall_instr", instr_out, 16'h1111);
      chk("t2_stall_pc", pc_out, 16'h0000);
      cyc();
    end
    stall = 1'b0;
    #1;
    chk1("t2_req_a", bus.imem_req, 1'b1);
    chk("t2_addr_a", bus.imem_addr, 16'h0002);
    cyc();
    chk1("t2_consumed", instr_valid, 1'b0);
    stall = 1'b1;
    #1;
    chk1("t2_req_b", bus.imem_req, 1'b1);
    chk("t2_addr_b", bus.imem_addr, 16'h0002);
    cyc();
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h2222;
    #1;
    chk("t2_addr_c", bus.imem_addr, 16'h0002);
    cyc();
    bus.imem_rdy = 1'b0;
    stall = 1'b0;
    chk("t2_instr", instr_out, 16'h2222);
    chk("t2_pc_out", pc_out, 16'h0002);
    chk1("t2_valid", instr_valid, 1'b1);

    // redirect while fetch of 0006 pending
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h3333;
    #1;
    chk("t3_addr4", bus.imem_addr, 16'h0004);
    cyc();
    bus.imem_rdy = 1'b0;
    #1;
    chk("t3_addr6", bus.imem_addr, 16'h0006);
    cyc();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk1("t3_req_redir", bus.imem_req, 1'b1);
    chk("t3_addr_redir", bus.imem_addr, 16'h0006);
    cyc();
    redirect = 1'b0;
    #1;
    chk1("t3_drain_req", bus.imem_req, 1'b1);
    chk("t3_drain_addr", bus.imem_addr, 16'h0006);
    chk1("t3_drain_valid", instr_valid, 1'b0);
    cyc();
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'hDEAD;
    #1;
    chk("t3_drain_addr2", bus.imem_addr, 16'h0006);
    cyc();
    bus.imem_rdy = 1'b0;
    #1;
    chk1("t3_discard_valid", instr_valid, 1'b0);
    chk1("t3_new_req", bus.imem_req, 1'b1);
    chk("t3_new_addr", bus.imem_addr, 16'h0040);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h4444;
    cyc();
    bus.imem_rdy = 1'b0;
    chk("t3_instr", instr_out, 16'h4444);
    chk("t3_pc_out", pc_out, 16'h0040);
    chk1("t3_valid", instr_valid, 1'b1);

    // redirect + rdy same cycle, stalled valid buffer
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h5555;
    #1;
    chk1("t4_req", bus.imem_req, 1'b0);
    cyc();
    redirect = 1'b0;
    bus.imem_rdy = 1'b0;
    chk1("t4_valid", instr_valid, 1'b0);
    #1;
    chk1("t4_next_req", bus.imem_req, 1'b1);
    chk("t4_next_addr", bus.imem_addr, 16'h0010);

    // HLT at 0010
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'hF000;
    cyc();
    bus.imem_rdy = 1'b0;
    #1;
    chk1("t5_halted", halted, 1'b1);
    chk1("t5_valid", instr_valid, 1'b1);
    chk("t5_instr", instr_out, 16'hF000);
    chk("t5_pc_out", pc_out, 16'h0010);
    chk("t5_pc_plus", pc_plus, 16'h0012);
    chk1("t5_req", bus.imem_req, 1'b0);
    cyc();
    chk1("t5_held", instr_valid, 1'b1);
    stall = 1'b0;
    cyc();
    chk1("t5_consumed", instr_valid, 1'b0);
    chk1("t5_still_halted", halted, 1'b1);
    #1;
    chk1("t5_no_req", bus.imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    cyc();
    redirect = 1'b0;
    #1;
    chk1("t5_unhalt", halted, 1'b0);
    chk1("t5_req2", bus.imem_req, 1'b1);
    chk("t5_addr2", bus.imem_addr, 16'h0020);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h7777;
    cyc();
    bus.imem_rdy = 1'b0;
    chk("t5_pc_out2", pc_out, 16'h0020);
    chk("t5_instr2", instr_out, 16'h7777);

    // wrap at FFFE and mid-operation reset
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    chk1("t6_req_redir", bus.imem_req, 1'b0);
    cyc();
    redirect = 1'b0;
    chk1("t6_flush", instr_valid, 1'b0);
    #1;
    chk("t6_addr", bus.imem_addr, 16'hFFFE);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h8888;
    cyc();
    bus.imem_rdy = 1'b0;
    #1;
    chk("t6_pc_out", pc_out, 16'hFFFE);
    chk("t6_pc_plus", pc_plus, 16'h0000);
    chk1("t6_req_wrap", bus.imem_req, 1'b1);
    chk("t6_addr_wrap", bus.imem_addr, 16'h0000);
    cyc();
    #1;
    chk1("t6_pend_req", bus.imem_req, 1'b1);
    chk("t6_pend_addr", bus.imem_addr, 16'h0000);
    rst = 1'b1;
    cyc();
    chk("t6_rst_instr", instr_out, 16'h0000);
    chk("t6_rst_pc_out", pc_out, 16'h0000);
    chk("t6_rst_pc_plus", pc_plus, 16'h0000);
    chk1("t6_rst_valid", instr_valid, 1'b0);
    chk1("t6_rst_halted", halted, 1'b0);
    rst = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    cyc();
    redirect = 1'b0;
    #1;
    chk1("t6_post_req", bus.imem_req, 1'b1);
    chk("t6_post_addr", bus.imem_addr, 16'h0100);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h9999;
    cyc();
    bus.imem_rdy = 1'b0;
    chk("t6_post_pc_out", pc_out, 16'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
